// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter
// ----------------------------------------------------------------------------
// Round-robin scheduler that lets several independent packet sources share a
// single ethernet_udp_transmit instance. The winning requester's payload is
// latched into tx_data, a one-cycle tx_send pulse is issued, and the
// transmitter's ready level is tracked through a whole packet: ready must fall
// (packet accepted) and then rise again (packet finished). The owner gets a
// done pulse on completion, or an error pulse if the watchdog expires first.
//
// Ports:
//   clk        system clock
//   rstn       asynchronous active-low reset
//   req        level request per requester, held until its done/error pulse
//   req_data   packed payloads, requester k at [k*8*DATA_BYTES +: 8*DATA_BYTES]
//   grant      one-hot, high while that requester's packet is in flight
//   done       one-cycle completion pulse to the packet owner
//   error      one-cycle watchdog-timeout pulse to the packet owner
//   tx_data    registered payload for the transmitter
//   tx_send    one-cycle send strobe for the transmitter
//   tx_ready   transmitter ready level
//   sent_count number of completed packets, wraps at 16 bits
// ----------------------------------------------------------------------------
module udp_tx_arbiter #(
   parameter int REQUESTERS     = 4,
   parameter int DATA_BYTES     = 256,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                               clk,
   input  logic                               rstn,
   input  logic [REQUESTERS-1:0]              req,
   input  logic [REQUESTERS*8*DATA_BYTES-1:0] req_data,
   output logic [REQUESTERS-1:0]              grant,
   output logic [REQUESTERS-1:0]              done,
   output logic [REQUESTERS-1:0]              error,
   output logic [8*DATA_BYTES-1:0]            tx_data,
   output logic                               tx_send,
   input  logic                               tx_ready,
   output logic [15:0]                        sent_count
);

   localparam int PAYLOAD_W = 8 * DATA_BYTES;
   localparam int IDX_W     = $clog2(REQUESTERS);
   localparam int WD_W      = $clog2(TIMEOUT_CYCLES) + 1;

   // The watchdog register holds the number of wait cycles already completed,
   // so the cycle currently being spent is number wd+1. Firing when that
   // reaches TIMEOUT_CYCLES-1 places the error pulse exactly TIMEOUT_CYCLES
   // cycles after the SEND cycle once the registered output delay is added.
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 2);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT_BUSY,
      ST_WAIT_DONE
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [IDX_W-1:0]       last;
   logic [IDX_W-1:0]       pick;
   logic                   pick_valid;
   logic [PAYLOAD_W-1:0]   pick_data;
   logic [WD_W-1:0]        wd;
   logic                   start;
   logic                   finish_ok;
   logic                   finish_timeout;

   // Round-robin search: walk upward from the requester after the last
   // winner, wrapping around, and take the first active request. The previous
   // winner is examined last, so it only wins again if nobody else is waiting.
   always_comb begin
      int cand;
      pick_valid = 1'b0;
      pick       = '0;
      cand       = 0;
      for (int i = 1; i <= REQUESTERS; i++) begin
         cand = (int'(last) + i) % REQUESTERS;
         if (!pick_valid && req[IDX_W'(cand)]) begin
            pick_valid = 1'b1;
            pick       = IDX_W'(cand);
         end
      end
   end

   // Payload multiplexer for the candidate winner; it is only captured into
   // tx_data on the cycle the grant is issued.
   always_comb begin
      pick_data = '0;
      for (int k = 0; k < REQUESTERS; k++) begin
         if (pick == IDX_W'(k)) begin
            pick_data = req_data[k*PAYLOAD_W +: PAYLOAD_W];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and the one-cycle event strobes that drive the
   // registered outputs. A grant is only issued while the transmitter reports
   // ready, which also covers the case of a packet still draining after a
   // reset. In WAIT_DONE a ready seen on the limit cycle still counts as a
   // completion because the transmitter did finish the packet.
   always_comb begin
      state_next     = state;
      start          = 1'b0;
      finish_ok      = 1'b0;
      finish_timeout = 1'b0;
      case (state)
         ST_IDLE: begin
            if (tx_ready && pick_valid) begin
               start      = 1'b1;
               state_next = ST_SEND;
            end
         end
         ST_SEND: begin
            state_next = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (wd == WD_LIMIT) begin
               finish_timeout = 1'b1;
               state_next     = ST_IDLE;
            end else if (!tx_ready) begin
               state_next = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (tx_ready) begin
               finish_ok  = 1'b1;
               state_next = ST_IDLE;
            end else if (wd == WD_LIMIT) begin
               finish_timeout = 1'b1;
               state_next     = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Watchdog: cleared in SEND, counts every cycle spent waiting on the
   // transmitter, and holds otherwise.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wd <= '0;
      end else if (state == ST_SEND) begin
         wd <= '0;
      end else if (state == ST_WAIT_BUSY || state == ST_WAIT_DONE) begin
         wd <= wd + WD_W'(1);
      end
   end

   // Rotation pointer. It advances at grant time, so a requester whose packet
   // times out still moves to the back of the rotation. Reset points it at the
   // highest index so that requester 0 has first priority.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         last <= IDX_W'(REQUESTERS - 1);
      end else if (start) begin
         last <= pick;
      end
   end

   // Grant and payload. tx_data is only reloaded on a new grant, so the owner
   // may change its req_data as soon as its grant is visible.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         grant   <= '0;
         tx_data <= '0;
      end else if (start) begin
         grant   <= {{(REQUESTERS-1){1'b0}}, 1'b1} << pick;
         tx_data <= pick_data;
      end else if (finish_ok || finish_timeout) begin
         grant <= '0;
      end
   end

   // Single-cycle strobes. done/error are steered by the current grant, which
   // is one-hot, and the two finish strobes are mutually exclusive, so at most
   // one bit of either vector can ever be set.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tx_send <= 1'b0;
         done    <= '0;
         error   <= '0;
      end else begin
         tx_send <= start;
         done    <= finish_ok ? grant : '0;
         error   <= finish_timeout ? grant : '0;
      end
   end

   // Completed-packet counter; timeouts do not count.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sent_count <= '0;
      end else if (finish_ok) begin
         sent_count <= sent_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb_udp_tx_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for udp_tx_arbiter. A cycle-based transmitter model
// answers each tx_send by dropping ready after acc_dly cycles and raising it
// again busy_len cycles later. Expected winners come from a plain round-robin
// reference function; payload expectations come from the bench's own stimulus.
// ----------------------------------------------------------------------------
module tb_udp_tx_arbiter;

   localparam int N    = 4;
   localparam int DB   = 4;
   localparam int PW   = 8 * DB;
   localparam int TOTW = N * PW;
   localparam int TMO  = 100;

   logic            clk = 1'b0;
   logic            rstn;
   logic [N-1:0]    req;
   logic [TOTW-1:0] req_data;
   logic [N-1:0]    grant;
   logic [N-1:0]    done;
   logic [N-1:0]    error;
   logic [PW-1:0]   tx_data;
   logic            tx_send;
   logic            tx_ready;
   logic [15:0]     sent_count;

   int tests = 0;
   int fails = 0;

   // Transmitter model controls (written by the test sequence only).
   int   acc_dly      = 1;
   int   busy_len     = 1;
   logic never_accept = 1'b0;
   logic model_abort  = 1'b0;
   logic hold_low     = 1'b0;

   // Transmitter model state (written by the model process only).
   logic model_ready = 1'b1;
   int   phase       = 0;
   int   cnt         = 0;

   // Monitor state (written by the monitor process only).
   int   cyc         = 0;
   int   send_pulses = 0;
   int   done_pulses = 0;
   logic bad_pulse   = 1'b0;

   assign tx_ready = model_ready & ~hold_low;

   udp_tx_arbiter #(
      .REQUESTERS     (N),
      .DATA_BYTES     (DB),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .req        (req),
      .req_data   (req_data),
      .grant      (grant),
      .done       (done),
      .error      (error),
      .tx_data    (tx_data),
      .tx_send    (tx_send),
      .tx_ready   (tx_ready),
      .sent_count (sent_count)
   );

   always #5 clk = ~clk;

   // Cycle counter, read by the sequence at 1 time unit after each edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   // Transmitter model: acts 2 time units after the edge so it reacts to the
   // registered tx_send of the current cycle and to controls set at +1.
   always @(posedge clk) begin
      #2;
      if (model_abort) begin
         phase       <= 0;
         model_ready <= 1'b1;
      end else if (phase == 0) begin
         if (tx_send && !never_accept) begin
            cnt   <= acc_dly;
            phase <= 1;
         end
      end else if (cnt == 1) begin
         if (phase == 1) begin
            model_ready <= 1'b0;
            cnt         <= busy_len;
            phase       <= 2;
         end else begin
            model_ready <= 1'b1;
            phase       <= 0;
         end
      end else begin
         cnt <= cnt - 1;
      end
   end

   // Pulse bookkeeping and one-hot / exclusivity watch.
   always @(negedge clk) begin
      if (tx_send) send_pulses <= send_pulses + 1;
      if (done != '0) done_pulses <= done_pulses + 1;
      if ((done != '0 && error != '0) || $countones(done) > 1 ||
          $countones(error) > 1 || $countones(grant) > 1)
         bad_pulse <= 1'b1;
   end

   // Reference round-robin: first requester set, scanning upward from last+1.
   function automatic int rr_pick(input int last, input logic [N-1:0] mask);
      for (int i = 1; i <= N; i++) begin
         int c;
         c = (last + i) % N;
         if ((mask & (N'(1) << c)) != '0) return c;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int c);
      return N'(1) << c;
   endfunction

   function automatic logic [PW-1:0] slot(input int k);
      return PW'(req_data >> (k * PW));
   endfunction

   task automatic set_slot(input int k, input logic [PW-1:0] v);
      req_data = (req_data & ~(TOTW'({PW{1'b1}}) << (k * PW))) |
                 (TOTW'(v) << (k * PW));
   endtask

   task automatic fill_payloads();
      for (int k = 0; k < N; k++) set_slot(k, PW'($urandom) | PW'(1));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_send(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         tick();
         if (tx_send === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_done(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         tick();
         if (done !== '0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_error(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         tick();
         if (error !== '0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_reset();
      rstn         = 1'b0;
      req          = '0;
      model_abort  = 1'b1;
      hold_low     = 1'b0;
      never_accept = 1'b0;
      repeat (3) tick();
      rstn        = 1'b1;
      model_abort = 1'b0;
      tick();
   endtask

   // Reset state of every output.
   task automatic test_reset();
      req_data = '0;
      do_reset();
      tests++; if (grant !== '0) begin fails++; $display("[TB] FAIL reset_grant got %b want 0", grant); end
      tests++; if (done !== '0) begin fails++; $display("[TB] FAIL reset_done got %b want 0", done); end
      tests++; if (error !== '0) begin fails++; $display("[TB] FAIL reset_error got %b want 0", error); end
      tests++; if (tx_send !== 1'b0) begin fails++; $display("[TB] FAIL reset_send got %b want 0", tx_send); end
      tests++; if (tx_data !== '0) begin fails++; $display("[TB] FAIL reset_data got %h want 0", tx_data); end
      tests++; if (sent_count !== 16'd0) begin fails++; $display("[TB] FAIL reset_count got %0d want 0", sent_count); end
   endtask

   // One request, fixed transmitter timing, exact latencies.
   task automatic test_single();
      bit ok;
      int s;
      int d;
      do_reset();
      acc_dly  = 20;
      busy_len = 30;
      fill_payloads();
      req_data[2*PW +: 8] = 8'hA5;
      req = 4'b0100;
      tick();
      s = cyc;
      tests++; if (tx_send !== 1'b1) begin fails++; $display("[TB] FAIL single_send got %b want 1", tx_send); end
      tests++; if (grant !== 4'b0100) begin fails++; $display("[TB] FAIL single_grant got %b want 0100", grant); end
      tests++; if (tx_data[7:0] !== 8'hA5) begin fails++; $display("[TB] FAIL single_byte0 got %h want a5", tx_data[7:0]); end
      tests++; if (tx_data !== slot(2)) begin fails++; $display("[TB] FAIL single_data got %h want %h", tx_data, slot(2)); end
      tick();
      tests++; if (tx_send !== 1'b0) begin fails++; $display("[TB] FAIL single_send_width got %b want 0", tx_send); end
      wait_done(200, ok);
      d = cyc;
      tests++; if (!ok) begin fails++; $display("[TB] FAIL single_done_wait got timeout want done"); end
      tests++; if (d - s != 51) begin fails++; $display("[TB] FAIL single_done_cycle got %0d want 51", d - s); end
      tests++; if (done !== 4'b0100) begin fails++; $display("[TB] FAIL single_done got %b want 0100", done); end
      tests++; if (grant !== '0) begin fails++; $display("[TB] FAIL single_grant_drop got %b want 0", grant); end
      tests++; if (sent_count !== 16'd1) begin fails++; $display("[TB] FAIL single_count got %0d want 1", sent_count); end
      req = '0;
      tick();
      tests++; if (done !== '0) begin fails++; $display("[TB] FAIL single_done_width got %b want 0", done); end
   endtask

   // All requesters held: strict rotation starting at requester 0.
   task automatic test_round_robin();
      bit ok;
      int last_m;
      int w;
      int sends0;
      do_reset();
      fill_payloads();
      acc_dly  = int'($urandom_range(1, 4));
      busy_len = 10;
      last_m   = N - 1;
      sends0   = send_pulses;
      req      = 4'b1111;
      for (int p = 0; p < 5; p++) begin
         w = rr_pick(last_m, req);
         wait_send(20, ok);
         tests++; if (!ok) begin fails++; $display("[TB] FAIL rr_send_wait pkt %0d got timeout want send", p); end
         tests++; if (grant !== onehot(w)) begin fails++; $display("[TB] FAIL rr_grant pkt %0d got %b want %b", p, grant, onehot(w)); end
         tests++; if (tx_data !== slot(w)) begin fails++; $display("[TB] FAIL rr_data pkt %0d got %h want %h", p, tx_data, slot(w)); end
         wait_done(60, ok);
         tests++; if (done !== onehot(w)) begin fails++; $display("[TB] FAIL rr_done pkt %0d got %b want %b", p, done, onehot(w)); end
         last_m = w;
      end
      req = '0;
      tick();
      tests++; if (sent_count !== 16'd5) begin fails++; $display("[TB] FAIL rr_count got %0d want 5", sent_count); end
      tests++; if (send_pulses - sends0 != 5) begin fails++; $display("[TB] FAIL rr_send_pulses got %0d want 5", send_pulses - sends0); end
   endtask

   // Random request mixes, payload changes and request drops after grant.
   task automatic test_back_to_back();
      bit ok;
      int last_m;
      int w;
      logic [PW-1:0] exp;
      do_reset();
      fill_payloads();
      last_m = N - 1;
      req    = N'($urandom_range(1, (1 << N) - 1));
      for (int p = 0; p < 10; p++) begin
         if (req == '0) req = N'($urandom_range(1, (1 << N) - 1));
         w        = rr_pick(last_m, req);
         exp      = slot(w);
         acc_dly  = int'($urandom_range(1, 4));
         busy_len = int'($urandom_range(1, 12));
         wait_send(20, ok);
         tests++; if (!ok) begin fails++; $display("[TB] FAIL b2b_send_wait pkt %0d got timeout want send", p); end
         tests++; if (grant !== onehot(w)) begin fails++; $display("[TB] FAIL b2b_grant pkt %0d got %b want %b", p, grant, onehot(w)); end
         tests++; if (tx_data !== exp) begin fails++; $display("[TB] FAIL b2b_data pkt %0d got %h want %h", p, tx_data, exp); end
         set_slot(w, ~exp);
         if ($urandom_range(0, 1) == 1) req = req & ~onehot(w);
         req = req | N'($urandom_range(0, (1 << N) - 1));
         wait_done(100, ok);
         tests++; if (done !== onehot(w)) begin fails++; $display("[TB] FAIL b2b_done pkt %0d got %b want %b", p, done, onehot(w)); end
         tests++; if (tx_data !== exp) begin fails++; $display("[TB] FAIL b2b_hold pkt %0d got %h want %h", p, tx_data, exp); end
         set_slot(w, PW'($urandom));
         last_m = w;
      end
      req = '0;
      tick();
      tests++; if (sent_count !== 16'd10) begin fails++; $display("[TB] FAIL b2b_count got %0d want 10", sent_count); end
   endtask

   // Transmitter never accepts: watchdog fires, rotation still advances.
   task automatic test_timeout();
      bit ok;
      int k;
      int k2;
      int w;
      int other;
      int s;
      int e;
      int done0;
      do_reset();
      fill_payloads();
      k        = int'($urandom_range(0, N - 1));
      k2       = (k + 1 + int'($urandom_range(0, N - 2))) % N;
      req      = onehot(k) | onehot(k2);
      w        = rr_pick(N - 1, req);
      other    = (w == k) ? k2 : k;
      acc_dly  = 2;
      busy_len = 5;
      never_accept = 1'b1;
      done0    = done_pulses;
      wait_send(10, ok);
      s = cyc;
      tests++; if (grant !== onehot(w)) begin fails++; $display("[TB] FAIL tmo_grant got %b want %b", grant, onehot(w)); end
      wait_error(300, ok);
      e = cyc;
      tests++; if (!ok) begin fails++; $display("[TB] FAIL tmo_error_wait got timeout want error"); end
      tests++; if (e - s != TMO) begin fails++; $display("[TB] FAIL tmo_cycle got %0d want %0d", e - s, TMO); end
      tests++; if (error !== onehot(w)) begin fails++; $display("[TB] FAIL tmo_error got %b want %b", error, onehot(w)); end
      tests++; if (grant !== '0) begin fails++; $display("[TB] FAIL tmo_grant_drop got %b want 0", grant); end
      tests++; if (done_pulses != done0) begin fails++; $display("[TB] FAIL tmo_no_done got %0d want 0", done_pulses - done0); end
      tests++; if (sent_count !== 16'd0) begin fails++; $display("[TB] FAIL tmo_count got %0d want 0", sent_count); end
      never_accept = 1'b0;
      wait_send(10, ok);
      tests++; if (grant !== onehot(other)) begin fails++; $display("[TB] FAIL tmo_next_grant got %b want %b", grant, onehot(other)); end
      wait_done(60, ok);
      tests++; if (done !== onehot(other)) begin fails++; $display("[TB] FAIL tmo_next_done got %b want %b", done, onehot(other)); end
      req = '0;
      tick();
   endtask

   // Asynchronous reset in WAIT_DONE, then no grant until ready returns.
   task automatic test_reset_mid();
      bit ok;
      bit saw;
      do_reset();
      fill_payloads();
      acc_dly  = 3;
      busy_len = 8;
      req      = 4'b0010;
      wait_send(10, ok);
      wait_done(60, ok);
      req      = 4'b0100;
      busy_len = 40;
      wait_send(10, ok);
      repeat (10) tick();
      #2;
      rstn        = 1'b0;
      model_abort = 1'b1;
      hold_low    = 1'b1;
      #1;
      tests++; if (grant !== '0) begin fails++; $display("[TB] FAIL rmid_grant got %b want 0", grant); end
      tests++; if (tx_data !== '0) begin fails++; $display("[TB] FAIL rmid_data got %h want 0", tx_data); end
      tests++; if (sent_count !== 16'd0) begin fails++; $display("[TB] FAIL rmid_count got %0d want 0", sent_count); end
      tests++; if ({done, error, tx_send} !== '0) begin fails++; $display("[TB] FAIL rmid_strobes got %b want 0", {done, error, tx_send}); end
      req = 4'b1001;
      repeat (2) tick();
      rstn        = 1'b1;
      model_abort = 1'b0;
      saw         = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (grant !== '0 || tx_send !== 1'b0) saw = 1'b1;
      end
      tests++; if (saw) begin fails++; $display("[TB] FAIL rmid_wait_ready got grant want none"); end
      busy_len = 6;
      hold_low = 1'b0;
      wait_send(5, ok);
      tests++; if (grant !== 4'b0001) begin fails++; $display("[TB] FAIL rmid_first_grant got %b want 0001", grant); end
      wait_done(60, ok);
      req = '0;
      tick();
   endtask

   task automatic test_pulse_integrity();
      tests++; if (bad_pulse !== 1'b0) begin fails++; $display("[TB] FAIL pulse_onehot got %b want 0", bad_pulse); end
   endtask

   initial begin
      rstn     = 1'b0;
      req      = '0;
      req_data = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      test_pulse_integrity();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
